alu_seq_4bit: RTL and testbench
===============================

Name: alu_seq_4bit

Overview:
- Sequential 4-bit ALU execution stage that accepts operands and an opcode over a valid/ready handshake.
- Computes AND, OR and XOR bitwise in one cycle; computes ADD bit-serially over 4 cycles using a single full-adder slice and a registered carry.
- Holds the result, with carry, zero and overflow flags, in an output register until the consumer takes it.
- Sits between the operand/opcode source and the result consumer (register file or display).

Parameters:
- SERIAL_ADD, 1, 1 = ADD takes 4 bit-serial cycles; 0 = ADD completes in 1 cycle like the logic ops.

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- a  input  4  operand A
- b  input  4  operand B
- op  input  2  opcode: 00 AND, 01 OR, 10 XOR, 11 ADD
- in_valid  input  1  a/b/op are valid this cycle
- in_ready  output  1  stage can accept an operation this cycle
- result  output  4  registered result
- carry  output  1  ADD carry-out; 0 for logic ops
- zero  output  1  1 when result == 4'b0000
- ovf  output  1  ADD signed overflow (a[3]==b[3] && result[3]!=a[3]); 0 for logic ops
- out_valid  output  1  result/flags valid
- out_ready  input  1  consumer accepts the result this cycle

Behaviour:
- Reset: clk and rst only; rst is synchronous and active-high. On a rising clk edge with rst=1:
  - state goes to IDLE;
  - result=0, carry=0, zero=0, ovf=0, out_valid=0;
  - bit counter=0, internal carry=0.
  - rst has priority over every other event, including mid-ADD; any operation in flight is discarded.
- States: IDLE, ADD, DONE.
- Handshake:
  - An operation is accepted on an edge where in_valid && in_ready.
  - in_ready = (state==IDLE) || (state==DONE && out_ready). Back-to-back operation is allowed when the consumer drains.
  - A result transfers on an edge where out_valid && out_ready.
  - in_valid while in_ready=0 is ignored; the source must hold its inputs.
- Operand capture: a, b and op are latched at accept. Input changes after accept have no effect on the operation in flight.
- Logic ops (op != 11, or SERIAL_ADD=0):
  - result, carry and ovf are written on the accept edge; state goes to DONE.
  - out_valid rises the cycle after accept (latency 1).
  - For SERIAL_ADD=0, ADD gives result = (a+b)[3:0] and carry = (a+b)[4].
- Serial ADD (op==11, SERIAL_ADD=1):
  - Accept edge: state goes to ADD, counter=0, internal carry=0.
  - Each ADD cycle i=0..3: sum bit = a[i]^b[i]^c; c' = majority(a[i], b[i], c). result[i] and c are written, then the counter increments.
  - On the edge that processes i=3: carry=c', ovf is computed, state goes to DONE.
  - out_valid rises 4 cycles after the accept edge (latency 4).
  - During the ADD state, result holds partially updated bits and out_valid=0.
- DONE:
  - out_valid=1; result and flags are held stable while out_ready=0, for an unbounded time.
  - out_ready=1 with no new accept: state goes to IDLE and out_valid goes to 0.
  - out_ready=1 with a simultaneous accept: the new operation starts that edge (state to DONE or ADD) and the old result is considered consumed.
- zero: combinational from the result register, qualified by out_valid (zero=0 when out_valid=0).
- Width rules: all datapath is 4 bits; ADD wraps modulo 16, with carry as bit 4; there is no saturation.

Test Plan:
- Reset then AND: a=1100, b=1010, op=00, out_ready=1 -> out_valid 1 cycle after accept, result=1000, carry=0, zero=0, ovf=0.
- XOR zero: a=0110, b=0110, op=10 -> result=0000, zero=1; OR a=0101, b=0010 -> result=0111.
- Serial ADD wrap: a=1111, b=0001, op=11 -> in_ready=0 for 4 cycles, out_valid on cycle 4, result=0000, carry=1, zero=1, ovf=0. Second case a=0111, b=0001 -> result=1000, carry=0, ovf=1.
- Backpressure: result pending with out_ready=0 for 10 cycles while in_valid=1 with new operands -> result stable, in_ready=0, new op not accepted. Raise out_ready -> the pending op is accepted the same edge and its result follows at latency 1 or 4.
- Back-to-back: four AND ops with in_valid=1 and out_ready=1 continuously -> one result per cycle, no bubbles, results in order.
- Reset mid-ADD: assert rst on the 2nd ADD cycle -> next cycle all outputs 0, state IDLE, in_ready=1. A following ADD a=0011, b=0101 -> result=1000, carry=0, ovf=1.

Source files
------------

// File: rtl/alu_seq_4bit.sv
// 4-bit ALU stage: AND/OR/XOR in one cycle, ADD bit-serially through one full-adder slice.
// Latency: out_valid 1 cycle after accept for logic ops, 4 cycles after the accept edge for serial ADD.
// Backpressure: result and flags are held while out_ready=0; in_ready drops until the result drains.
module alu_seq_4bit #(
  parameter bit SERIAL_ADD = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [1:0] op,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [3:0] result,
  output logic       carry,
  output logic       zero,
  output logic       ovf,
  output logic       out_valid,
  input  logic       out_ready
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_ADD = 2'b11;

  state_t     state;
  state_t     state_nxt;

  // Handshake qualifiers
  logic       accept;
  logic       serial_start;

  // Operands captured for the serial adder; the source may change a/b after accept
  logic [3:0] a_q;
  logic [3:0] b_q;
  logic [1:0] bit_cnt;
  logic       c_int;

  // Single-cycle datapath results
  logic [4:0] sum_full;
  logic [3:0] fast_res;
  logic       fast_carry;
  logic       fast_ovf;

  // Serial full-adder slice
  logic       a_bit;
  logic       b_bit;
  logic       sum_bit;
  logic       c_next;
  logic       last_bit;

  // A new op can enter when idle, or when the held result is being taken this same edge
  assign in_ready     = (state == ST_IDLE) || ((state == ST_DONE) && out_ready);
  assign accept       = in_valid && in_ready;
  assign serial_start = accept && (op == OP_ADD) && SERIAL_ADD;

  assign out_valid    = (state == ST_DONE);
  // zero must not advertise a stale or partial result
  assign zero         = out_valid && (result == 4'b0000);

  assign sum_full     = {1'b0, a} + {1'b0, b};

  // One-cycle result for logic ops, and for ADD when the serial path is disabled
  always_comb begin
    fast_res   = 4'b0000;
    fast_carry = 1'b0;
    fast_ovf   = 1'b0;
    case (op)
      OP_AND: fast_res = a & b;
      OP_OR:  fast_res = a | b;
      OP_XOR: fast_res = a ^ b;
      OP_ADD: begin
        fast_res   = sum_full[3:0];
        fast_carry = sum_full[4];
        fast_ovf   = (a[3] == b[3]) && (sum_full[3] != a[3]);
      end
      default: fast_res = 4'b0000;
    endcase
  end

  // Bit slice for the serial adder: one sum bit and the ripple carry per cycle
  always_comb begin
    a_bit    = a_q[bit_cnt];
    b_bit    = b_q[bit_cnt];
    sum_bit  = a_bit ^ b_bit ^ c_int;
    c_next   = (a_bit & b_bit) | (a_bit & c_int) | (b_bit & c_int);
    last_bit = (bit_cnt == 2'd3);
  end

  // Next-state logic for IDLE -> (ADD ->) DONE -> IDLE, with DONE able to chain straight into a new op
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_nxt = serial_start ? ST_ADD : ST_DONE;
        end
      end
      ST_ADD: begin
        if (last_bit) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        if (accept) begin
          state_nxt = serial_start ? ST_ADD : ST_DONE;
        end else if (out_ready) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State register; reset wins over any in-flight operation
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Result/flag registers and serial adder bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      result  <= 4'b0000;
      carry   <= 1'b0;
      ovf     <= 1'b0;
      a_q     <= 4'b0000;
      b_q     <= 4'b0000;
      bit_cnt <= 2'd0;
      c_int   <= 1'b0;
    end else if (accept) begin
      if (serial_start) begin
        // result bits are overwritten one per cycle; flags settle on the last bit
        a_q     <= a;
        b_q     <= b;
        bit_cnt <= 2'd0;
        c_int   <= 1'b0;
        carry   <= 1'b0;
        ovf     <= 1'b0;
      end else begin
        result  <= fast_res;
        carry   <= fast_carry;
        ovf     <= fast_ovf;
      end
    end else if (state == ST_ADD) begin
      result[bit_cnt] <= sum_bit;
      c_int           <= c_next;
      bit_cnt         <= bit_cnt + 2'd1;
      if (last_bit) begin
        carry <= c_next;
        ovf   <= (a_q[3] == b_q[3]) && (sum_bit != a_q[3]);
      end
    end
  end

endmodule

// File: tb/tb_alu_seq_4bit.sv
module tb_alu_seq_4bit;

  logic       clk;
  logic       rst;
  logic [3:0] a;
  logic [3:0] b;
  logic [1:0] op;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] result;
  logic       carry;
  logic       zero;
  logic       ovf;
  logic       out_valid;
  logic       out_ready;

  int total;
  int bad;

  alu_seq_4bit #(.SERIAL_ADD(1'b1)) dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .b         (b),
    .op        (op),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .result    (result),
    .carry     (carry),
    .zero      (zero),
    .ovf       (ovf),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] va;
    logic [3:0] vb;
    logic [1:0] vop;
    logic [3:0] res;
    logic       c;
    logic       z;
    logic       v;
    int         wait_e;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Issue one op from an idle/draining stage; returns edges after the accept edge until out_valid
  task automatic issue(input logic [3:0] ta, input logic [3:0] tb, input logic [1:0] top,
                       input string tag, output int edges);
    @(negedge clk);
    chk({tag, " in_ready_before"}, {7'd0, in_ready}, 8'd1);
    a = ta;
    b = tb;
    op = top;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = ~ta;
    b = ~tb;
    edges = 0;
    @(negedge clk);
    while (!out_valid && edges < 20) begin
      chk({tag, " in_ready_busy"}, {7'd0, in_ready}, 8'd0);
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    int e;
    total = 0;
    bad = 0;
    rst = 1'b1;
    a = 4'd0;
    b = 4'd0;
    op = 2'b00;
    in_valid = 1'b0;
    out_ready = 1'b1;

    //              a        b        op     result   c     z     v   wait
    vecs[0] = '{4'b1100, 4'b1010, 2'b00, 4'b1000, 1'b0, 1'b0, 1'b0, 0};
    vecs[1] = '{4'b0110, 4'b0110, 2'b10, 4'b0000, 1'b0, 1'b1, 1'b0, 0};
    vecs[2] = '{4'b0101, 4'b0010, 2'b01, 4'b0111, 1'b0, 1'b0, 1'b0, 0};
    vecs[3] = '{4'b1111, 4'b0001, 2'b11, 4'b0000, 1'b1, 1'b1, 1'b0, 4};
    vecs[4] = '{4'b0111, 4'b0001, 2'b11, 4'b1000, 1'b0, 1'b0, 1'b1, 4};
    vecs[5] = '{4'b0000, 4'b1111, 2'b00, 4'b0000, 1'b0, 1'b1, 1'b0, 0};
    vecs[6] = '{4'b1010, 4'b0101, 2'b10, 4'b1111, 1'b0, 1'b0, 1'b0, 0};
    vecs[7] = '{4'b0101, 4'b0110, 2'b11, 4'b1011, 1'b0, 1'b0, 1'b1, 4};
    vecs[8] = '{4'b1000, 4'b1000, 2'b11, 4'b0000, 1'b1, 1'b1, 1'b1, 4};
    vecs[9] = '{4'b0000, 4'b0000, 2'b01, 4'b0000, 1'b0, 1'b1, 1'b0, 0};

    // Reset state
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst result", {4'd0, result}, 8'd0);
    chk("rst carry", {7'd0, carry}, 8'd0);
    chk("rst zero", {7'd0, zero}, 8'd0);
    chk("rst ovf", {7'd0, ovf}, 8'd0);
    chk("rst out_valid", {7'd0, out_valid}, 8'd0);
    chk("rst in_ready", {7'd0, in_ready}, 8'd1);

    // Directed vector table
    for (int i = 0; i < 10; i++) begin
      string t;
      t = $sformatf("vec%0d", i);
      issue(vecs[i].va, vecs[i].vb, vecs[i].vop, t, e);
      chk({t, " latency"}, 8'(e), 8'(vecs[i].wait_e));
      chk({t, " out_valid"}, {7'd0, out_valid}, 8'd1);
      chk({t, " result"}, {4'd0, result}, {4'd0, vecs[i].res});
      chk({t, " carry"}, {7'd0, carry}, {7'd0, vecs[i].c});
      chk({t, " zero"}, {7'd0, zero}, {7'd0, vecs[i].z});
      chk({t, " ovf"}, {7'd0, ovf}, {7'd0, vecs[i].v});
    end

    // Backpressure: AND pending, XOR waiting at the input for 10 cycles
    @(negedge clk);
    out_ready = 1'b0;
    a = 4'b1100;
    b = 4'b1010;
    op = 2'b00;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    a = 4'b0011;
    b = 4'b0101;
    op = 2'b10;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk($sformatf("bp%0d result", k), {4'd0, result}, 8'h08);
      chk($sformatf("bp%0d in_ready", k), {7'd0, in_ready}, 8'd0);
      chk($sformatf("bp%0d out_valid", k), {7'd0, out_valid}, 8'd1);
    end
    out_ready = 1'b1;
    #1;
    chk("bp in_ready_drain", {7'd0, in_ready}, 8'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("bp next out_valid", {7'd0, out_valid}, 8'd1);
    chk("bp next result", {4'd0, result}, 8'h06);
    @(posedge clk);
    @(negedge clk);
    chk("bp drained", {7'd0, out_valid}, 8'd0);

    // Back-to-back ANDs, one result per cycle
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i > 0) begin
        chk($sformatf("b2b%0d out_valid", i - 1), {7'd0, out_valid}, 8'd1);
        chk($sformatf("b2b%0d result", i - 1), {4'd0, result}, 8'(1 << (i - 1)));
      end
      chk($sformatf("b2b%0d in_ready", i), {7'd0, in_ready}, 8'd1);
      a = 4'b1111;
      b = 4'(1 << i);
      op = 2'b00;
      in_valid = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk("b2b3 out_valid", {7'd0, out_valid}, 8'd1);
    chk("b2b3 result", {4'd0, result}, 8'h08);
    @(posedge clk);

    // Reset during the second ADD cycle
    @(negedge clk);
    a = 4'b1111;
    b = 4'b0001;
    op = 2'b11;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("mid in_ready_add1", {7'd0, in_ready}, 8'd0);
    @(posedge clk);
    @(negedge clk);
    chk("mid out_valid_add2", {7'd0, out_valid}, 8'd0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("mid result", {4'd0, result}, 8'd0);
    chk("mid carry", {7'd0, carry}, 8'd0);
    chk("mid zero", {7'd0, zero}, 8'd0);
    chk("mid ovf", {7'd0, ovf}, 8'd0);
    chk("mid out_valid", {7'd0, out_valid}, 8'd0);
    chk("mid in_ready", {7'd0, in_ready}, 8'd1);
    issue(4'b0011, 4'b0101, 2'b11, "post", e);
    chk("post latency", 8'(e), 8'd4);
    chk("post result", {4'd0, result}, 8'h08);
    chk("post carry", {7'd0, carry}, 8'd0);
    chk("post ovf", {7'd0, ovf}, 8'd1);
    chk("post zero", {7'd0, zero}, 8'd0);

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
